uart_rx_io: RTL and testbench
=============================

# uart_rx_io

Receive half of the host UART: deserializes an 8N1 stream on `uart_rx` with 16x oversampling, buffers bytes in a small FIFO, and exposes data and status to the Z80 on two I/O ports. It sits beside the transmit-side `uart_io` on the same Z80 I/O bus. Each block decodes its own port addresses and drives `Data` only during its own read cycles.

## Interface
- `CLOCK_FREQ`, 50000000: system clock in Hz.
- `BAUD`, 115200: line rate; tick divisor `DIV = CLOCK_FREQ/(16*BAUD)` must be >= 1.
- `FIFO_DEPTH`, 4: receive FIFO entries; must be a power of two.
- `DATA_PORT`, 8'd9: read pops the FIFO head.
- `STATUS_PORT`, 8'd11: read returns status; a write clears sticky errors.
- `clk` in 1: system clock.
- `reset` in 1: one clock; reset is synchronous and active-low.
- `uart_rx` in 1: asynchronous serial input; idles high.
- `Address` in 8: Z80 I/O address, low byte.
- `Data` inout 8: driven only while `IORQ==0`, `RD==0` and `Address` matches a port; high-Z otherwise.
- `IORQ`, `RD`, `WR` in 1: Z80 strobes, active-low.
- `rx_ready` out 1: FIFO not empty. Reset value 0.

## Operation
- **Input synchronizer.** 2-flop synchronizer on `uart_rx`. Both flops reset to 1.
- **Tick generator.** A counter produces a 1-clock `tick` every `DIV` clocks. It restarts on start-bit detection.
- **FSM states.** WAIT_IDLE (reset state), IDLE, START, DATA, STOP.
  - WAIT_IDLE -> IDLE when the synced line is 1. This prevents a line held low at reset release from being taken as a start bit.
  - IDLE -> START on a synced 1->0 edge. Clear the tick counter.
  - START: at tick 8 (mid-bit), a line of 0 -> DATA. A line of 1 is a glitch -> IDLE, nothing recorded.
  - DATA: sample every 16 ticks and shift in LSB first. After bit 7 -> STOP.
  - STOP: sample at 16 ticks.
    - Line 1: push the byte, then -> IDLE.
    - Line 0: set `ferr`, discard the byte, then -> WAIT_IDLE.
- **FIFO push/pop.**
  - Push when full (and no pop in the same cycle): drop the new byte and set `ovr`.
  - Push and pop in the same cycle: both occur; the count is unchanged; no overrun, even if full.
  - Pop when empty: ignored. The read returns 8'h00.
- **Bus read.** An access is `IORQ==0 && RD==0 && Address==port`.
  - `Data` = FIFO head combinationally for the whole access, so it is stable across multi-clock strobes.
  - The pop happens on the first clock after the access ends (registered access-active flag falls), exactly once per access.
- **Status byte.** `{4'b0, full, ferr, ovr, not_empty}`.
- **Status write.** `IORQ==0 && WR==0 && Address==STATUS_PORT` clears `ovr` and `ferr` on the first clock of the access.
  - A simultaneous new error event wins: the flag stays set.
- **Reset.** All of the following are cleared:
  - FIFO pointers and count
  - `ovr` and `ferr`
  - shift register
  - FSM -> WAIT_IDLE

  A partial frame is discarded.

## Timing
- Start-edge detection lags the pin by 2 clocks (synchronizer).
- Byte visible (`rx_ready`=1, status bit0) 1 clock after the stop-bit sample tick.
- Frame length is 160 ticks. Back-to-back frames are accepted: STOP returns to IDLE at the stop-bit midpoint.
- `Data` output is combinational from head/status and the address decode. No wait states.
- `rx_ready` falls 1 clock after the access that popped the last byte ends.

## Structure
- **Package `uart_pkg`:**
  - rx state enum
  - status bit index constants
  - default port address constants
- **Sub-module `uart_rx_core`:** synchronizer, tick generator, FSM and shift register.
  - Outputs: `rx_byte[7:0]`, `rx_valid` (1-clock pulse), `rx_ferr` (1-clock pulse).
- **Wrapper `uart_rx_io`:** FIFO, sticky flags, bus decode and tri-state.

## Test plan
All cases use `BAUD = CLOCK_FREQ/16` (16 clocks/bit).
- **Single byte.** Send 0x34.
  - Status read returns 8'h01 and data read returns 8'h34.
  - After the access ends: status 8'h00 and `rx_ready`=0.
- **Fill FIFO.** Send 0x55, 0xAA, 0x0F, 0xF0 back-to-back.
  - Status 8'h09.
  - Four data reads return 0x55, 0xAA, 0x0F, 0xF0 in order; then status 8'h00.
- **Overrun.** Send a fifth byte 0x99 while full.
  - Status 8'h0B.
  - Reads return the first four bytes only.
  - A write to port 11 clears the flag -> status 8'h00.
  - Repeat, with a pop ending in the same clock as the push: no overrun, 0x99 is retained.
- **Framing error.** Send 0xA5 with stop bit 0, then hold the line low for 40 clocks, then high.
  - Status 8'h04 and no byte stored.
  - A following byte 0x12 is received correctly; status 8'h05.
- **Glitch.** Pulse `uart_rx` low for 4 clocks.
  - No byte, status stays 8'h00, and the FSM returns to IDLE.
- **Reset mid-frame.** Assert `reset`=0 for 1 clock during bit 3 of 0x7E, with the line low at release.
  - FIFO empty and no spurious start.
  - The next full frame 0x3C is read back as 0x3C.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the host UART receive path: receiver states,
// status byte layout and the default Z80 I/O port map.
package uart_pkg;

    typedef enum logic [2:0] {
        RX_WAIT_IDLE,
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    localparam int STAT_NOT_EMPTY = 0;
    localparam int STAT_OVR       = 1;
    localparam int STAT_FERR      = 2;
    localparam int STAT_FULL      = 3;

    localparam logic [7:0] DEFAULT_DATA_PORT   = 8'd9;
    localparam logic [7:0] DEFAULT_STATUS_PORT = 8'd11;

    // Clocks per oversampling tick (16 ticks per bit).
    function automatic int tick_divisor(input int clock_freq, input int baud);
        return clock_freq / (16 * baud);
    endfunction

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 deserializer with 16x oversampling: synchronizer, tick generator,
// receive FSM and shift register. Emits one-clock byte/error pulses.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int DIV = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uart_rx,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       rx_ferr
);

    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic             sync1;
    logic             sync2;
    logic             line_prev;
    logic             armed;
    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    logic [3:0]       tick_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shreg;
    rx_state_t        state;
    rx_state_t        state_next;

    logic start_edge;
    logic clr_ticks;
    logic restart_bit;
    logic shift_en;
    logic mid_start;
    logic bit_done;

    assign start_edge = line_prev & ~sync2;
    assign tick       = (div_cnt == DIV_W'(DIV - 1));
    assign mid_start  = tick && (tick_cnt == 4'd7);
    assign bit_done   = tick && (tick_cnt == 4'd15);
    assign rx_byte    = shreg;

    // armed marks that sync1 now holds a real pin sample rather than its reset value.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1     <= 1'b1;
            sync2     <= 1'b1;
            line_prev <= 1'b1;
            armed     <= 1'b0;
        end else begin
            sync1     <= uart_rx;
            sync2     <= sync1;
            line_prev <= sync2;
            armed     <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset || clr_ticks) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset || clr_ticks || restart_bit) begin
            tick_cnt <= 4'd0;
        end else if (tick) begin
            tick_cnt <= tick_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            bit_cnt <= 3'd0;
            shreg   <= 8'h00;
        end else begin
            if (restart_bit) begin
                bit_cnt <= 3'd0;
            end else if (shift_en) begin
                bit_cnt <= bit_cnt + 3'd1;
            end
            if (shift_en) begin
                shreg <= {sync2, shreg[7:1]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= RX_WAIT_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        clr_ticks   = 1'b0;
        restart_bit = 1'b0;
        shift_en    = 1'b0;
        rx_valid    = 1'b0;
        rx_ferr     = 1'b0;
        unique case (state)
            RX_WAIT_IDLE: begin
                // Require both flops high so a line held low through reset is not seen as idle.
                if (armed && sync1 && sync2) begin
                    state_next = RX_IDLE;
                end
            end
            RX_IDLE: begin
                if (start_edge) begin
                    clr_ticks  = 1'b1;
                    state_next = RX_START;
                end
            end
            RX_START: begin
                if (mid_start) begin
                    if (!sync2) begin
                        restart_bit = 1'b1;
                        state_next  = RX_DATA;
                    end else begin
                        state_next = RX_IDLE;
                    end
                end
            end
            RX_DATA: begin
                if (bit_done) begin
                    shift_en = 1'b1;
                    if (bit_cnt == 3'd7) begin
                        state_next = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (bit_done) begin
                    if (sync2) begin
                        rx_valid   = 1'b1;
                        state_next = RX_IDLE;
                    end else begin
                        rx_ferr    = 1'b1;
                        state_next = RX_WAIT_IDLE;
                    end
                end
            end
            default: state_next = RX_WAIT_IDLE;
        endcase
    end

endmodule

// File: rtl/uart_rx_io.sv
// Z80 I/O front end for the UART receiver: byte FIFO, sticky overrun and
// framing flags, port decode and the tri-state data bus driver.
module uart_rx_io
    import uart_pkg::*;
#(
    parameter int         CLOCK_FREQ  = 50000000,
    parameter int         BAUD        = 115200,
    parameter int         FIFO_DEPTH  = 4,
    parameter logic [7:0] DATA_PORT   = DEFAULT_DATA_PORT,
    parameter logic [7:0] STATUS_PORT = DEFAULT_STATUS_PORT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uart_rx,
    input  logic [7:0] Address,
    inout  wire  [7:0] Data,
    input  logic       IORQ,
    input  logic       RD,
    input  logic       WR,
    output logic       rx_ready
);

    localparam int DIV   = tick_divisor(CLOCK_FREQ, BAUD);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    logic [7:0]       rx_byte;
    logic             rx_valid;
    logic             rx_ferr;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             not_empty;
    logic             ovr_flag;
    logic             ferr_flag;

    logic             data_rd_acc;
    logic             stat_rd_acc;
    logic             stat_wr_acc;
    logic             data_rd_q;
    logic             stat_wr_q;
    logic             do_pop;
    logic             do_push;
    logic             ovr_set;
    logic             err_clr;
    logic [7:0]       head;
    logic [7:0]       status_byte;

    uart_rx_core #(
        .DIV(DIV)
    ) u_core (
        .clk     (clk),
        .reset   (reset),
        .uart_rx (uart_rx),
        .rx_byte (rx_byte),
        .rx_valid(rx_valid),
        .rx_ferr (rx_ferr)
    );

    assign data_rd_acc = !IORQ && !RD && (Address == DATA_PORT);
    assign stat_rd_acc = !IORQ && !RD && (Address == STATUS_PORT);
    assign stat_wr_acc = !IORQ && !WR && (Address == STATUS_PORT);

    assign full      = (count == CNT_W'(FIFO_DEPTH));
    assign not_empty = (count != '0);
    assign rx_ready  = not_empty;

    // Pop once, on the clock where a data-port read has just ended; the head
    // stays on the bus for the whole access however long the strobe is held.
    assign do_pop  = data_rd_q && !data_rd_acc && not_empty;
    assign do_push = rx_valid && (!full || do_pop);
    assign ovr_set = rx_valid && full && !do_pop;
    assign err_clr = stat_wr_acc && !stat_wr_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            data_rd_q <= 1'b0;
            stat_wr_q <= 1'b0;
        end else begin
            data_rd_q <= data_rd_acc;
            stat_wr_q <= stat_wr_acc;
        end
    end

    // When full with a simultaneous pop, wr_ptr equals rd_ptr and the new
    // byte safely replaces the entry being consumed.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= rx_byte;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // A new error event in the clearing cycle takes priority over the clear.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ovr_flag  <= 1'b0;
            ferr_flag <= 1'b0;
        end else begin
            if (ovr_set) begin
                ovr_flag <= 1'b1;
            end else if (err_clr) begin
                ovr_flag <= 1'b0;
            end
            if (rx_ferr) begin
                ferr_flag <= 1'b1;
            end else if (err_clr) begin
                ferr_flag <= 1'b0;
            end
        end
    end

    always_comb begin
        head                        = not_empty ? mem[rd_ptr] : 8'h00;
        status_byte                 = 8'h00;
        status_byte[STAT_FULL]      = full;
        status_byte[STAT_FERR]      = ferr_flag;
        status_byte[STAT_OVR]       = ovr_flag;
        status_byte[STAT_NOT_EMPTY] = not_empty;
    end

    assign Data = data_rd_acc ? head :
                  stat_rd_acc ? status_byte : 8'hzz;

endmodule

// File: tb/tb_uart_rx_io.sv
// Randomized and directed bench for uart_rx_io, checked against a FIFO/flag
// model that updates once per complete frame and per bus access.
module tb_uart_rx_io;

    localparam int         CLK_HZ      = 1600000;
    localparam int         BAUD        = 100000;
    localparam int         DEPTH       = 4;
    localparam logic [7:0] DATA_PORT   = 8'd9;
    localparam logic [7:0] STATUS_PORT = 8'd11;

    logic       clk = 1'b0;
    logic       reset;
    logic       uart_rx;
    logic [7:0] Address;
    logic       IORQ;
    logic       RD;
    logic       WR;
    wire  [7:0] Data;
    logic       rx_ready;

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] q[$];
    logic       m_ovr;
    logic       m_ferr;
    logic [7:0] pushPopSample;
    logic [7:0] expHead;

    always #5 clk = ~clk;

    uart_rx_io #(
        .CLOCK_FREQ (CLK_HZ),
        .BAUD       (BAUD),
        .FIFO_DEPTH (DEPTH),
        .DATA_PORT  (DATA_PORT),
        .STATUS_PORT(STATUS_PORT)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .uart_rx (uart_rx),
        .Address (Address),
        .Data    (Data),
        .IORQ    (IORQ),
        .RD      (RD),
        .WR      (WR),
        .rx_ready(rx_ready)
    );

    initial begin
        #5ms;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 8'h%02h expected 8'h%02h", tag, actual, expected);
        end
    endtask

    function automatic logic [7:0] expStatus();
        logic isFull;
        logic nonEmpty;
        isFull   = (q.size() == DEPTH);
        nonEmpty = (q.size() != 0);
        return {4'b0000, isFull, m_ferr, m_ovr, nonEmpty};
    endfunction

    task automatic modelFrame(input logic [7:0] b, input bit stopOk);
        if (!stopOk) m_ferr = 1'b1;
        else if (q.size() < DEPTH) q.push_back(b);
        else m_ovr = 1'b1;
    endtask

    task automatic modelReset();
        q.delete();
        m_ovr  = 1'b0;
        m_ferr = 1'b0;
    endtask

    // Drives one 8N1 frame at 16 clocks per bit. With popAtPush, a data read
    // is timed to end so its pop lands on the same clock as the stop-bit push.
    task automatic applyStimulus(input logic [7:0] b, input bit stopOk, input bit popAtPush);
        logic [9:0] bits;
        bits = {stopOk, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            uart_rx = bits[k];
            for (int j = 1; j < 16; j++) begin
                @(negedge clk);
                if (popAtPush && k == 9) begin
                    if (j == 8) begin
                        Address = DATA_PORT;
                        IORQ    = 1'b0;
                        RD      = 1'b0;
                        #1 pushPopSample = Data;
                    end
                    if (j == 10) begin
                        IORQ    = 1'b1;
                        RD      = 1'b1;
                        Address = 8'h00;
                    end
                end
            end
        end
    endtask

    task automatic sendGood(input logic [7:0] b);
        applyStimulus(b, 1'b1, 1'b0);
        modelFrame(b, 1'b1);
    endtask

    task automatic sendBad(input logic [7:0] b);
        applyStimulus(b, 1'b0, 1'b0);
        repeat (40) @(negedge clk);
        uart_rx = 1'b1;
        repeat (8) @(negedge clk);
        modelFrame(b, 1'b0);
    endtask

    task automatic readAccess(input logic [7:0] port, input int len, output logic [7:0] first, output logic [7:0] last);
        @(negedge clk);
        Address = port;
        IORQ    = 1'b0;
        RD      = 1'b0;
        #1 first = Data;
        last = first;
        for (int i = 1; i < len; i++) begin
            @(negedge clk);
            #1 last = Data;
        end
        @(negedge clk);
        IORQ    = 1'b1;
        RD      = 1'b1;
        Address = 8'h00;
    endtask

    task automatic readData(input string tag, input int len);
        logic [7:0] exp, first, last;
        exp = (q.size() != 0) ? q[0] : 8'h00;
        readAccess(DATA_PORT, len, first, last);
        checkOutput(tag, first, exp);
        if (len > 1) checkOutput({tag, "_held"}, last, exp);
        if (q.size() != 0) void'(q.pop_front());
        @(negedge clk);
        #1 checkOutput({tag, "_ready"}, {7'b0, rx_ready}, {7'b0, q.size() != 0});
    endtask

    task automatic readStatus(input string tag, input int len);
        logic [7:0] exp, first, last;
        exp = expStatus();
        readAccess(STATUS_PORT, len, first, last);
        checkOutput(tag, last, exp);
    endtask

    task automatic writeStatus(input int len);
        @(negedge clk);
        Address = STATUS_PORT;
        IORQ    = 1'b0;
        WR      = 1'b0;
        repeat (len) @(negedge clk);
        IORQ    = 1'b1;
        WR      = 1'b1;
        Address = 8'h00;
        m_ovr   = 1'b0;
        m_ferr  = 1'b0;
    endtask

    task automatic otherPortRead(input int len);
        logic [7:0] first, last;
        readAccess(8'd10, len, first, last);
    endtask

    initial begin
        reset   = 1'b0;
        uart_rx = 1'b1;
        IORQ    = 1'b1;
        RD      = 1'b1;
        WR      = 1'b1;
        Address = 8'h00;
        modelReset();
        repeat (3) @(negedge clk);
        #1 checkOutput("reset_ready", {7'b0, rx_ready}, 8'h00);
        @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        readStatus("reset_status", 1);

        sendGood(8'h34);
        readStatus("single_status", 1);
        readData("single_data", 2);
        readStatus("single_after", 1);

        sendGood(8'h55); sendGood(8'hAA); sendGood(8'h0F); sendGood(8'hF0);
        readStatus("fill_status", 1);
        for (int i = 0; i < 4; i++) readData("fill_data", 1 + i % 3);
        readStatus("fill_after", 1);

        sendGood(8'h55); sendGood(8'hAA); sendGood(8'h0F); sendGood(8'hF0);
        sendGood(8'h99);
        readStatus("ovr_status", 1);
        for (int i = 0; i < 4; i++) readData("ovr_data", 1);
        readStatus("ovr_flag_only", 1);
        writeStatus(1);
        readStatus("ovr_cleared", 1);

        sendGood(8'h55); sendGood(8'hAA); sendGood(8'h0F); sendGood(8'hF0);
        expHead = q[0];
        applyStimulus(8'h99, 1'b1, 1'b1);
        checkOutput("pushpop_data", pushPopSample, expHead);
        void'(q.pop_front());
        modelFrame(8'h99, 1'b1);
        readStatus("pushpop_status", 1);
        for (int i = 0; i < 4; i++) readData("pushpop_drain", 1);
        readStatus("pushpop_after", 1);

        sendBad(8'hA5);
        readStatus("ferr_status", 1);
        sendGood(8'h12);
        readStatus("ferr_next_status", 1);
        readData("ferr_next_data", 1);
        writeStatus(2);
        readStatus("ferr_cleared", 1);

        @(negedge clk);
        uart_rx = 1'b0;
        repeat (4) @(negedge clk);
        uart_rx = 1'b1;
        repeat (40) @(negedge clk);
        readStatus("glitch_status", 1);
        sendGood(8'h5A);
        readData("glitch_next_data", 1);

        sendGood(8'h77);
        sendBad(8'hC3);
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (15) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            uart_rx = (k == 0) ? 1'b0 : 1'b1;
            repeat (16) @(negedge clk);
        end
        uart_rx = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        modelReset();
        repeat (20) @(negedge clk);
        uart_rx = 1'b1;
        repeat (200) @(negedge clk);
        #1 checkOutput("midreset_ready", {7'b0, rx_ready}, 8'h00);
        readStatus("midreset_status", 1);
        sendGood(8'h3C);
        readData("midreset_data", 1);

        for (int n = 0; n < 60; n++) begin
            int op;
            op = $urandom_range(0, 9);
            if (op <= 3) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
                sendGood(8'($urandom_range(0, 255)));
            end else if (op == 4) begin
                sendBad(8'($urandom_range(0, 255)));
            end else if (op <= 6) begin
                readData("rand_data", $urandom_range(1, 3));
            end else if (op == 7) begin
                readStatus("rand_status", $urandom_range(1, 3));
            end else if (op == 8) begin
                writeStatus($urandom_range(1, 2));
            end else begin
                otherPortRead($urandom_range(1, 2));
                readStatus("rand_other_port", 1);
            end
        end
        while (q.size() != 0) readData("final_drain", 1);
        readStatus("final_status", 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
